// File: rtl/fetch_queue_pkg.sv
// -----------------------------------------------------------------------------
// fetch_queue_pkg
//   Shared constants and the entry layout for the fetch/decode decoupling
//   queue.
//   - INST_NOP              : canonical NOP (addi x0, x0, 0) shown when empty
//   - SYSOP_INST_PAGE_FAULT : exception cause code of a fetch page fault
//   - fq_entry_t            : one buffered fetch {inst, pc, cause, tval}
// -----------------------------------------------------------------------------
package fetch_queue_pkg;

    localparam logic [31:0] INST_NOP              = 32'h0000_0013;
    localparam logic [4:0]  SYSOP_INST_PAGE_FAULT = 5'd12;

    localparam int INST_W  = 32;
    localparam int PC_W    = 64;
    localparam int CAUSE_W = 5;
    localparam int TVAL_W  = 64;
    localparam int ENTRY_W = INST_W + PC_W + CAUSE_W + TVAL_W;  // 165

    typedef struct packed {
        logic [INST_W-1:0]  inst;
        logic [PC_W-1:0]    pc;
        logic [CAUSE_W-1:0] cause;
        logic [TVAL_W-1:0]  tval;
    } fq_entry_t;

endpackage

// File: rtl/fq_mem.sv
// -----------------------------------------------------------------------------
// fq_mem
//   DEPTH x W register array holding queue entries. Data is never reset;
//   validity is tracked by the pointers and count in the parent.
//   Ports:
//     clk   in   clock
//     we    in   write enable
//     waddr in   write index
//     wdata in   write data
//     raddr in   read index (asynchronous read)
//     rdata out  entry at raddr
// -----------------------------------------------------------------------------
module fq_mem #(
    parameter int DEPTH = 4,
    parameter int W     = 165
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [W-1:0]             wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [W-1:0]             rdata
);

    logic [W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/fetch_queue.sv
// -----------------------------------------------------------------------------
// fetch_queue
//   Show-ahead FIFO between fetch and decode. Stops accepting entries after a
//   faulting fetch is enqueued until the next flush; flush discards everything.
//   Ports:
//     clk, rst                 clock, synchronous active-high reset
//     in_valid/in_ready        fetch side handshake
//     in_inst/pc/cause/tval    entry offered by fetch
//     flush                    redirect/trap: discard all entries
//     out_valid/out_ready      decode side handshake
//     out_inst/pc/cause/tval   head entry (NOP/0/0/0 when empty)
//     count                    occupancy
//     state_dbg                FSM state (0 = RUN, 1 = FAULT_HOLD)
//
//   Handshake: a transfer happens on a rising edge exactly when valid and
//   ready are both high in the preceding cycle. The producer holds its
//   payload while valid is high and ready is low. in_ready never depends on
//   out_ready, and out_* never depend combinationally on in_*.
// -----------------------------------------------------------------------------
module fetch_queue
    import fetch_queue_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [31:0]              in_inst,
    input  logic [63:0]              in_pc,
    input  logic [4:0]               in_cause,
    input  logic [63:0]              in_tval,
    input  logic                     flush,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [31:0]              out_inst,
    output logic [63:0]              out_pc,
    output logic [4:0]               out_cause,
    output logic [63:0]              out_tval,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     state_dbg
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic {
        RUN        = 1'b0,
        FAULT_HOLD = 1'b1
    } state_t;

    state_t        state_q;
    state_t        state_d;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count_q;
    logic          enq;
    logic          deq;
    fq_entry_t     wr_entry;
    fq_entry_t     head;
    logic [ENTRY_W-1:0] head_raw;

    // flush masks in_ready, so no enqueue can slip in during a flush cycle.
    // A dequeue in a flush cycle is discarded along with everything else.
    assign enq = in_valid & in_ready;
    assign deq = out_valid & out_ready & ~flush;

    assign wr_entry.inst  = in_inst;
    assign wr_entry.pc    = in_pc;
    assign wr_entry.cause = in_cause;
    assign wr_entry.tval  = in_tval;

    fq_mem #(
        .DEPTH (DEPTH),
        .W     (ENTRY_W)
    ) u_mem (
        .clk   (clk),
        .we    (enq),
        .waddr (wr_ptr),
        .wdata (wr_entry),
        .raddr (rd_ptr),
        .rdata (head_raw)
    );

    assign head = fq_entry_t'(head_raw);

    // Pointers and occupancy. Pointers wrap naturally modulo DEPTH.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (enq) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (deq) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({enq, deq})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // FSM: state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM: next state. Any accepted entry carrying an exception closes the
    // input until the pipeline redirects.
    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = RUN;
        end else begin
            case (state_q)
                RUN: begin
                    if (enq && (in_cause != 5'd0)) begin
                        state_d = FAULT_HOLD;
                    end
                end
                FAULT_HOLD: state_d = FAULT_HOLD;
                default:    state_d = RUN;
            endcase
        end
    end

    // FSM: outputs. Full blocks input even if the head leaves this cycle,
    // keeping out_ready off the in_ready path.
    always_comb begin
        in_ready  = (state_q == RUN) && (count_q < CW'(DEPTH)) && !flush;
        out_valid = (count_q != '0);
        state_dbg = (state_q == FAULT_HOLD);
    end

    // Show-ahead head view with fixed defaults when empty.
    always_comb begin
        out_inst  = INST_NOP;
        out_pc    = '0;
        out_cause = '0;
        out_tval  = '0;
        if (out_valid) begin
            out_inst  = head.inst;
            out_pc    = head.pc;
            out_cause = head.cause;
            out_tval  = head.tval;
        end
    end

    assign count = count_q;

endmodule

// File: tb/tb_fetch_queue.sv
module tb_fetch_queue;
    import fetch_queue_pkg::*;

    localparam int DEPTH = 4;
    localparam int W     = 165;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_inst = '0;
    logic [63:0] in_pc = '0;
    logic [4:0]  in_cause = '0;
    logic [63:0] in_tval = '0;
    logic        flush = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_inst;
    logic [63:0] out_pc;
    logic [4:0]  out_cause;
    logic [63:0] out_tval;
    logic [$clog2(DEPTH):0] count;
    logic        state_dbg;

    int tests = 0;
    int fails = 0;
    logic [W-1:0] exp_q[$];

    fetch_queue #(.DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_inst   (in_inst),
        .in_pc     (in_pc),
        .in_cause  (in_cause),
        .in_tval   (in_tval),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_inst  (out_inst),
        .out_pc    (out_pc),
        .out_cause (out_cause),
        .out_tval  (out_tval),
        .count     (count),
        .state_dbg (state_dbg)
    );

    // ---------------- clock / watchdog ----------------
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, tests=%0d", tests);
        $fatal(1, "watchdog");
    end

    // ---------------- helpers / driver tasks ----------------
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One fetch cycle: offer an entry, check in_ready (and count when
    // exp_cnt >= 0) mid-cycle, record it if it should be accepted.
    task automatic enq_cycle(input logic [63:0] pc, input logic [4:0] cause,
                             input logic [63:0] tval, input bit exp_acc,
                             input int exp_cnt);
        logic [31:0] inst;
        inst     = pc[31:0] ^ 32'hA5A5_0000;
        in_valid = 1'b1;
        in_pc    = pc;
        in_inst  = inst;
        in_cause = cause;
        in_tval  = tval;
        if (exp_acc) exp_q.push_back({inst, pc, cause, tval});
        @(negedge clk);
        chk("in_ready_on_offer", 64'(in_ready), 64'(exp_acc));
        if (exp_cnt >= 0) chk("count_on_offer", 64'(count), 64'(exp_cnt));
        step();
        in_valid = 1'b0;
    endtask

    task automatic chk_reset_outputs(input string tag);
        @(negedge clk);
        chk({tag, "_out_valid"}, 64'(out_valid), 64'd0);
        chk({tag, "_out_inst"},  64'(out_inst), 64'(INST_NOP));
        chk({tag, "_out_pc"},    out_pc, 64'd0);
        chk({tag, "_out_cause"}, 64'(out_cause), 64'd0);
        chk({tag, "_out_tval"},  out_tval, 64'd0);
        chk({tag, "_count"},     64'(count), 64'd0);
        chk({tag, "_in_ready"},  64'(in_ready), 64'd1);
        chk({tag, "_state"},     64'(state_dbg), 64'd0);
    endtask

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk) begin
        if (!rst && !flush && out_valid && out_ready) begin
            logic [W-1:0] e;
            tests++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL deq_unexpected: got pc 0x%0h expected no entry", out_pc);
            end else begin
                e = exp_q.pop_front();
                if ({out_inst, out_pc, out_cause, out_tval} !== e) begin
                    fails++;
                    $display("FAIL deq_entry: got pc 0x%0h inst 0x%0h cause %0d tval 0x%0h expected pc 0x%0h inst 0x%0h cause %0d tval 0x%0h",
                             out_pc, out_inst, out_cause, out_tval,
                             e[132:69], e[164:133], e[68:64], e[63:0]);
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        // Reset then idle
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        chk_reset_outputs("reset");

        // Fill to full with decode stalled
        step();
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            enq_cycle(64'h8000_0000 + 64'(4 * i), 5'd0, 64'd0, 1'b1, i);
        end
        @(negedge clk);
        chk("full_count",     64'(count), 64'd4);
        chk("full_in_ready",  64'(in_ready), 64'd0);
        chk("full_out_valid", 64'(out_valid), 64'd1);
        chk("full_head_pc",   out_pc, 64'h8000_0000);
        step();
        enq_cycle(64'h8000_0010, 5'd0, 64'd0, 1'b0, 4);
        // Drain
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) step();
        @(negedge clk);
        chk("drain_out_valid", 64'(out_valid), 64'd0);
        chk("drain_sb_empty",  64'(exp_q.size()), 64'd0);
        step();

        // Streaming, pointers wrap
        out_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            enq_cycle(64'h4000 + 64'(4 * i), 5'd0, 64'd0, 1'b1, (i == 0) ? 0 : 1);
        end
        step();
        @(negedge clk);
        chk("stream_out_valid", 64'(out_valid), 64'd0);
        chk("stream_sb_empty",  64'(exp_q.size()), 64'd0);
        step();

        // Fetch page fault closes the input
        out_ready = 1'b0;
        enq_cycle(64'h1000, SYSOP_INST_PAGE_FAULT, 64'h1000, 1'b1, 0);
        enq_cycle(64'h1004, 5'd0, 64'd0, 1'b0, 1);
        @(negedge clk);
        chk("fault_state", 64'(state_dbg), 64'd1);
        chk("fault_head_cause", 64'(out_cause), 64'(SYSOP_INST_PAGE_FAULT));
        step();
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        @(negedge clk);
        chk("fault_drained_valid", 64'(out_valid), 64'd0);
        chk("fault_hold_in_ready", 64'(in_ready), 64'd0);
        chk("fault_hold_state",    64'(state_dbg), 64'd1);
        step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        @(negedge clk);
        chk("fault_flush_state",    64'(state_dbg), 64'd0);
        chk("fault_flush_in_ready", 64'(in_ready), 64'd1);
        step();

        // Flush with 3 entries, in_valid and out_ready all high
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            enq_cycle(64'h2000 + 64'(4 * i), 5'd0, 64'd0, 1'b1, i);
        end
        in_valid  = 1'b1;
        in_pc     = 64'h2100;
        in_inst   = 32'h0000_0093;
        in_cause  = 5'd0;
        out_ready = 1'b1;
        flush     = 1'b1;
        @(negedge clk);
        chk("flush_cycle_in_ready", 64'(in_ready), 64'd0);
        step();
        exp_q.delete();
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        chk_reset_outputs("flush");
        step();

        // Reset while in FAULT_HOLD with 2 entries
        enq_cycle(64'h3000, 5'd0, 64'd0, 1'b1, 0);
        enq_cycle(64'h3004, SYSOP_INST_PAGE_FAULT, 64'h3004, 1'b1, 1);
        @(negedge clk);
        chk("pre_rst_count", 64'(count), 64'd2);
        chk("pre_rst_state", 64'(state_dbg), 64'd1);
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        exp_q.delete();
        chk_reset_outputs("midrst");

        step();
        step();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
